// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold beats load; with none asserted it takes a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [31:0]       load_instr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (hold) begin
            valid <= valid;
            pc    <= pc;
            instr <= instr;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem request, stall skid buffer and redirect handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic [5:0]        if_id_opcode
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] target, target_n;
    logic [ADDR_W-1:0] skid_pc, skid_pc_n;
    logic [31:0]       skid, skid_n;
    logic              flush, hold, load;
    logic [ADDR_W-1:0] load_pc;
    logic [31:0]       load_instr;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc + ADDR_W'(PC_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            target  <= RESET_PC;
            skid_pc <= '0;
            skid    <= NOP_INSTR;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            target  <= target_n;
            skid_pc <= skid_pc_n;
            skid    <= skid_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        target_n   = target;
        skid_pc_n  = skid_pc;
        skid_n     = skid;
        flush      = 1'b0;
        hold       = 1'b0;
        load       = 1'b0;
        load_pc    = pc;
        load_instr = imem_rdata;
        unique case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (imem_rvalid) begin
                        pc_n = redirect_pc;
                    end else begin
                        // Request is still in flight; wait it out at the old address.
                        target_n = redirect_pc;
                        state_n  = DROP;
                    end
                end else if (imem_rvalid) begin
                    pc_n = pc_inc;
                    if (stall) begin
                        hold      = 1'b1;
                        skid_n    = imem_rdata;
                        skid_pc_n = pc;
                        state_n   = HOLD;
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    hold = stall;
                end
            end
            HOLD: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_n    = redirect_pc;
                    state_n = FETCH;
                end else if (stall) begin
                    hold = 1'b1;
                end else begin
                    load       = 1'b1;
                    load_pc    = skid_pc;
                    load_instr = skid;
                    state_n    = FETCH;
                end
            end
            DROP: begin
                flush = 1'b1;
                if (redirect) begin
                    target_n = redirect_pc;
                end
                if (imem_rvalid) begin
                    pc_n    = redirect ? redirect_pc : target;
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Request outputs come from registered state only.
    assign imem_req  = (state == FETCH) || (state == DROP);
    assign imem_addr = pc;

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold      (hold),
        .load      (load),
        .load_pc   (load_pc),
        .load_instr(load_instr),
        .valid     (if_id_valid),
        .pc        (if_id_pc),
        .instr     (if_id_instr)
    );

    assign if_id_opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an instruction memory returning word = address.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_opcode;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int wait_cnt;

    fetch_stage #(
        .ADDR_W  (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_opcode(if_id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after mem_lat wait cycles; mem_lat=0 answers in the request cycle.
    always_comb begin
        imem_rvalid = imem_req && (wait_cnt >= mem_lat);
        imem_rdata  = imem_addr;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (imem_req && !imem_rvalid) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_req_addr: got %h, want %h", {imem_req, imem_addr}, {1'b0, 32'h0});
        end
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, if_id_opcode} !== 71'h0) begin
            errors++;
            $display("FAIL reset_if_id: got %h, want 0", {if_id_valid, if_id_pc, if_id_instr, if_id_opcode});
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got %b, want 0", imem_req);
        end
    endtask

    task automatic test_zero_wait;
        logic [64:0] exp;
        tick();
        checks++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_req: got %h, want %h", {imem_req, imem_addr, if_id_valid}, {1'b1, 32'h0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {1'b1, 32'(i * 4), 32'(i * 4)};
            checks++;
            if ({if_id_valid, if_id_pc, if_id_instr} !== exp) begin
                errors++;
                $display("FAIL zero_wait_%0d: got %h, want %h", i, {if_id_valid, if_id_pc, if_id_instr}, exp);
            end
        end
        checks++;
        if (if_id_opcode !== 6'h00) begin
            errors++;
            $display("FAIL zero_wait_opcode: got %h, want 00", if_id_opcode);
        end
    endtask

    task automatic test_latency;
        mem_lat = 2;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({if_id_valid, if_id_instr, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'hC}) begin
                errors++;
                $display("FAIL latency_bubble_%0d: got %h, want %h", i,
                         {if_id_valid, if_id_instr, imem_req, imem_addr}, {1'b0, 32'h0, 1'b1, 32'hC});
            end
        end
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b1, 32'hC, 32'hC, 32'h10}) begin
            errors++;
            $display("FAIL latency_word: got %h, want %h",
                     {if_id_valid, if_id_pc, if_id_instr, imem_addr}, {1'b1, 32'hC, 32'hC, 32'h10});
        end
    endtask

    task automatic test_stall;
        mem_lat = 0;
        stall   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({if_id_valid, if_id_pc, if_id_instr, imem_req} !== {1'b1, 32'hC, 32'hC, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h, want %h", i,
                         {if_id_valid, if_id_pc, if_id_instr, imem_req}, {1'b1, 32'hC, 32'hC, 1'b0});
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr} !== {1'b1, 32'h10, 32'h10, 1'b1, 32'h14}) begin
            errors++;
            $display("FAIL stall_release: got %h, want %h",
                     {if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr}, {1'b1, 32'h10, 32'h10, 1'b1, 32'h14});
        end
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h14, 32'h14}) begin
            errors++;
            $display("FAIL stall_next: got %h, want %h", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 32'h14, 32'h14});
        end
    endtask

    task automatic test_redirect_pending;
        tick();
        tick();
        checks++;
        if ({if_id_pc, imem_addr} !== {32'h1C, 32'h20}) begin
            errors++;
            $display("FAIL pre_redirect: got %h, want %h", {if_id_pc, imem_addr}, {32'h1C, 32'h20});
        end
        mem_lat = 3;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        for (int i = 0; i < 2; i++) begin
            tick();
            redirect = 1'b0;
            checks++;
            if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h20, 1'b0}) begin
                errors++;
                $display("FAIL drop_addr_%0d: got %h, want %h", i, {imem_req, imem_addr, if_id_valid}, {1'b1, 32'h20, 1'b0});
            end
        end
        tick();
        checks++;
        if ({imem_addr, if_id_valid, if_id_pc, if_id_instr} !== {32'h100, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL drop_done: got %h, want %h",
                     {imem_addr, if_id_valid, if_id_pc, if_id_instr}, {32'h100, 1'b0, 32'h0, 32'h0});
        end
        mem_lat = 0;
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h100, 32'h100}) begin
            errors++;
            $display("FAIL target_word: got %h, want %h", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 32'h100, 32'h100});
        end
    endtask

    task automatic test_redirect_stall;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        stall       = 1'b1;
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h200}) begin
            errors++;
            $display("FAIL redirect_stall_flush: got %h, want %h",
                     {if_id_valid, if_id_pc, if_id_instr, imem_addr}, {1'b0, 32'h0, 32'h0, 32'h200});
        end
        stall       = 1'b0;
        mem_lat     = 2;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h400;
        checks++;
        if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL second_drop: got %h, want %h", {imem_req, imem_addr, if_id_valid}, {1'b1, 32'h200, 1'b0});
        end
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if ({imem_addr, if_id_valid} !== {32'h400, 1'b0}) begin
            errors++;
            $display("FAIL latest_target: got %h, want %h", {imem_addr, if_id_valid}, {32'h400, 1'b0});
        end
    endtask

    task automatic test_wrap_and_reset;
        mem_lat     = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr: got %h, want fffffffc", imem_addr);
        end
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, if_id_opcode, imem_addr} !==
            {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 6'h3F, 32'h0}) begin
            errors++;
            $display("FAIL wrap_word: got %h, want %h", {if_id_valid, if_id_pc, if_id_instr, if_id_opcode, imem_addr},
                     {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 6'h3F, 32'h0});
        end
        mem_lat = 3;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_opcode} !== 72'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h, want 0", {imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_opcode});
        end
        mem_lat = 0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reidle: got %b, want 0", imem_req);
        end
        tick();
        tick();
        checks++;
        if ({if_id_valid, if_id_pc, if_id_instr, imem_addr} !== {1'b1, 32'h0, 32'h0, 32'h4}) begin
            errors++;
            $display("FAIL restart: got %h, want %h", {if_id_valid, if_id_pc, if_id_instr, imem_addr}, {1'b1, 32'h0, 32'h0, 32'h4});
        end
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect_pending();
        test_redirect_stall();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
